// File: rtl/alsu_if.sv
// Operand/control bundle into the pipelined ALSU and its result/LED outputs.
interface alsu_if #(
   parameter int WIDTH = 4
);
   logic               in_valid;
   logic [WIDTH-1:0]   A;
   logic [WIDTH-1:0]   B;
   logic [2:0]         opcode;
   logic               cin;
   logic               serial_in;
   logic               direction;
   logic               red_op_A;
   logic               red_op_B;
   logic               bypass_A;
   logic               bypass_B;
   logic [2*WIDTH-1:0] out;
   logic               out_valid;
   logic               err;
   logic [15:0]        leds;

   modport master (
      output in_valid, A, B, opcode, cin, serial_in, direction,
             red_op_A, red_op_B, bypass_A, bypass_B,
      input  out, out_valid, err, leds
   );

   modport slave (
      input  in_valid, A, B, opcode, cin, serial_in, direction,
             red_op_A, red_op_B, bypass_A, bypass_B,
      output out, out_valid, err, leds
   );
endinterface

// File: rtl/alsu_pipe.sv
// Two-stage pipelined ALSU with invalid-op detection and an error LED blinker.
//
// state   | meaning
// S_IDLE  | no outstanding error, leds dark
// S_BLINK | last result was invalid, leds toggle every BLINK_DIV cycles
module alsu_pipe #(
   parameter int    WIDTH          = 4,
   parameter string FULL_ADDER     = "ON",
   parameter string INPUT_PRIORITY = "A",
   parameter int    BLINK_DIV      = 4
) (
   input logic   clk,
   input logic   rst,
   alsu_if.slave bus
);
   localparam int            OW       = 2 * WIDTH;
   localparam int            CW       = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [CW-1:0] C_TC     = CW'(BLINK_DIV - 1);
   localparam bit            L_FA     = (FULL_ADDER == "ON");
   localparam bit            L_PRIO_A = (INPUT_PRIORITY == "A");

   typedef enum logic {S_IDLE, S_BLINK} state_t;

   logic             r_v1;
   logic [WIDTH-1:0] r_a, r_b;
   logic [2:0]       r_op;
   logic             r_cin, r_sin, r_dir, r_red_a, r_red_b, r_byp_a, r_byp_b;

   logic [OW-1:0]    r_out;
   logic             r_err, r_out_valid;

   state_t           r_state, w_state_nx;
   logic [CW-1:0]    r_cnt, w_cnt_nx;
   logic [15:0]      r_leds, w_leds_nx;

   logic [WIDTH-1:0] w_red_opnd, w_byp_opnd;
   logic [WIDTH:0]   w_sum;
   logic             w_red, w_inv;
   logic [OW-1:0]    w_res;

   // Data registers only move on valid so idle cycles cost no toggling.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_v1 <= 1'b0;
      end else begin
         r_v1 <= bus.in_valid;
         if (bus.in_valid) begin
            r_a     <= bus.A;
            r_b     <= bus.B;
            r_op    <= bus.opcode;
            r_cin   <= bus.cin;
            r_sin   <= bus.serial_in;
            r_dir   <= bus.direction;
            r_red_a <= bus.red_op_A;
            r_red_b <= bus.red_op_B;
            r_byp_a <= bus.bypass_A;
            r_byp_b <= bus.bypass_B;
         end
      end
   end

   assign w_red      = r_red_a | r_red_b;
   assign w_inv      = (r_op[2:1] == 2'b11) || (w_red && (r_op[2:1] != 2'b00));
   assign w_red_opnd = (r_red_a && r_red_b) ? (L_PRIO_A ? r_a : r_b) : (r_red_a ? r_a : r_b);
   assign w_byp_opnd = (r_byp_a && r_byp_b) ? (L_PRIO_A ? r_a : r_b) : (r_byp_a ? r_a : r_b);
   assign w_sum      = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, r_cin & L_FA};

   always_comb begin
      w_res = '0;
      if (w_inv) begin
         w_res = '0;
      end else if (r_byp_a || r_byp_b) begin
         w_res = OW'(w_byp_opnd);
      end else begin
         case (r_op)
            3'b000:  w_res = w_red ? OW'(&w_red_opnd) : OW'(r_a & r_b);
            3'b001:  w_res = w_red ? OW'(^w_red_opnd) : OW'(r_a ^ r_b);
            3'b010:  w_res = OW'(w_sum);
            3'b011:  w_res = OW'(r_a) * OW'(r_b);
            3'b100:  w_res = r_dir ? OW'({r_a[WIDTH-2:0], r_sin})
                                   : OW'({r_sin, r_a[WIDTH-1:1]});
            3'b101:  w_res = r_dir ? OW'({r_a[WIDTH-2:0], r_a[WIDTH-1]})
                                   : OW'({r_a[0], r_a[WIDTH-1:1]});
            default: w_res = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out       <= '0;
         r_err       <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= r_v1;
         if (r_v1) begin
            r_out <= w_res;
            r_err <= w_inv;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_leds  <= '0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_leds  <= w_leds_nx;
      end
   end

   // A fresh result always wins over the divider toggle on the same edge.
   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_leds_nx  = r_leds;
      if (r_v1 && w_inv) begin
         w_state_nx = S_BLINK;
         w_cnt_nx   = '0;
         w_leds_nx  = 16'hFFFF;
      end else if (r_v1) begin
         w_state_nx = S_IDLE;
         w_cnt_nx   = '0;
         w_leds_nx  = '0;
      end else if (r_state == S_BLINK) begin
         if (r_cnt == C_TC) begin
            w_cnt_nx  = '0;
            w_leds_nx = ~r_leds;
         end else begin
            w_cnt_nx  = r_cnt + 1'b1;
         end
      end
   end

   assign bus.out       = r_out;
   assign bus.out_valid = r_out_valid;
   assign bus.err       = r_err;
   assign bus.leds      = r_leds;
endmodule
